// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the 5-stage MIPS core.
// Holds execute-stage results for the memory stage, with hold, bubble and flush.
module ex_mem_reg #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [5:0]     stall,
    input  logic           flush,
    input  logic [AW-1:0]  ex_wd,
    input  logic           ex_wreg,
    input  logic [DW-1:0]  ex_wdata,
    input  logic           ex_whilo,
    input  logic [DW-1:0]  ex_hi,
    input  logic [DW-1:0]  ex_lo,
    input  logic [OPW-1:0] ex_aluop,
    input  logic [DW-1:0]  ex_mem_addr,
    input  logic [DW-1:0]  ex_reg2,
    input  logic           ex_cp0_reg_we,
    input  logic [4:0]     ex_cp0_reg_write_addr,
    input  logic [DW-1:0]  ex_cp0_reg_data,
    input  logic [31:0]    ex_exc,
    input  logic           ex_is_in_delayslot,
    input  logic [DW-1:0]  ex_current_inst_address,
    output logic [AW-1:0]  mem_wd,
    output logic           mem_wreg,
    output logic [DW-1:0]  mem_wdata,
    output logic           mem_whilo,
    output logic [DW-1:0]  mem_hi,
    output logic [DW-1:0]  mem_lo,
    output logic [OPW-1:0] mem_aluop,
    output logic [DW-1:0]  mem_mem_addr,
    output logic [DW-1:0]  mem_reg2,
    output logic           mem_cp0_reg_we,
    output logic [4:0]     mem_cp0_reg_write_addr,
    output logic [DW-1:0]  mem_cp0_reg_data,
    output logic [31:0]    mem_exc,
    output logic           mem_is_in_delayslot,
    output logic [DW-1:0]  mem_current_inst_address,
    output logic           mem_valid
);

    logic clear;
    logic load;

    // A bubble is EX stalled while MEM advances; it clears like a flush.
    assign clear = flush || (stall[3] && !stall[4]);
    assign load  = !stall[3];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mem_wd                   <= '0;
            mem_wreg                 <= 1'b0;
            mem_wdata                <= '0;
            mem_whilo                <= 1'b0;
            mem_hi                   <= '0;
            mem_lo                   <= '0;
            mem_aluop                <= '0;
            mem_mem_addr             <= '0;
            mem_reg2                 <= '0;
            mem_cp0_reg_we           <= 1'b0;
            mem_cp0_reg_write_addr   <= '0;
            mem_cp0_reg_data         <= '0;
            mem_exc                  <= '0;
            mem_is_in_delayslot      <= 1'b0;
            mem_current_inst_address <= '0;
            mem_valid                <= 1'b0;
        end else if (load) begin
            mem_wd                   <= ex_wd;
            mem_wreg                 <= ex_wreg;
            mem_wdata                <= ex_wdata;
            mem_whilo                <= ex_whilo;
            mem_hi                   <= ex_hi;
            mem_lo                   <= ex_lo;
            mem_aluop                <= ex_aluop;
            mem_mem_addr             <= ex_mem_addr;
            mem_reg2                 <= ex_reg2;
            mem_cp0_reg_we           <= ex_cp0_reg_we;
            mem_cp0_reg_write_addr   <= ex_cp0_reg_write_addr;
            mem_cp0_reg_data         <= ex_cp0_reg_data;
            mem_exc                  <= ex_exc;
            mem_is_in_delayslot      <= ex_is_in_delayslot;
            mem_current_inst_address <= ex_current_inst_address;
            mem_valid                <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: stimulus pushes expected snapshots,
// a monitor pops and compares one snapshot after every clock edge.
module tb_ex_mem_reg;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2;
        logic        cp0_we;
        logic [4:0]  cp0_addr;
        logic [31:0] cp0_data;
        logic [31:0] exc;
        logic        dly;
        logic [31:0] pc;
    } in_t;

    typedef struct packed {
        in_t  d;
        logic valid;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [5:0] stall = 6'd0;
    in_t        din = '0;
    out_t       got;

    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic        mem_cp0_reg_we;
    logic [4:0]  mem_cp0_reg_write_addr;
    logic [31:0] mem_cp0_reg_data;
    logic [31:0] mem_exc;
    logic        mem_is_in_delayslot;
    logic [31:0] mem_current_inst_address;
    logic        mem_valid;

    out_t  exp_q[$];
    string name_q[$];
    out_t  model = '0;
    int    n_vec = 0;
    int    n_mis = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .ex_wd(din.wd),
        .ex_wreg(din.wreg),
        .ex_wdata(din.wdata),
        .ex_whilo(din.whilo),
        .ex_hi(din.hi),
        .ex_lo(din.lo),
        .ex_aluop(din.aluop),
        .ex_mem_addr(din.mem_addr),
        .ex_reg2(din.reg2),
        .ex_cp0_reg_we(din.cp0_we),
        .ex_cp0_reg_write_addr(din.cp0_addr),
        .ex_cp0_reg_data(din.cp0_data),
        .ex_exc(din.exc),
        .ex_is_in_delayslot(din.dly),
        .ex_current_inst_address(din.pc),
        .mem_wd(mem_wd),
        .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo),
        .mem_hi(mem_hi),
        .mem_lo(mem_lo),
        .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr),
        .mem_reg2(mem_reg2),
        .mem_cp0_reg_we(mem_cp0_reg_we),
        .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr),
        .mem_cp0_reg_data(mem_cp0_reg_data),
        .mem_exc(mem_exc),
        .mem_is_in_delayslot(mem_is_in_delayslot),
        .mem_current_inst_address(mem_current_inst_address),
        .mem_valid(mem_valid)
    );

    assign got = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
                  mem_aluop, mem_mem_addr, mem_reg2, mem_cp0_reg_we,
                  mem_cp0_reg_write_addr, mem_cp0_reg_data, mem_exc,
                  mem_is_in_delayslot, mem_current_inst_address, mem_valid};

    // Drive one edge's inputs and record what the slot must hold after it.
    task automatic step(input string nm, input logic r, input logic f,
                        input logic [5:0] s, input in_t d);
        @(negedge clk);
        rst   = r;
        flush = f;
        stall = s;
        din   = d;
        if (r || f)
            model = '0;
        else if (s[3] && !s[4])
            model = '0;
        else if (!s[3])
            model = {d, 1'b1};
        exp_q.push_back(model);
        name_q.push_back(nm);
    endtask

    function automatic in_t rnd_in();
        in_t v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        return v;
    endfunction

    // Monitor: one expected snapshot per edge, sampled 1 time unit later.
    initial begin
        out_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_vec++;
                if (got !== e) begin
                    n_mis++;
                    $display("FAIL %s: got=%h required=%h", nm, got, e);
                end
                if (nm == "hold_addr" &&
                    (mem_mem_addr !== 32'h80000010 || mem_aluop !== 8'hA3)) begin
                    n_mis++;
                    $display("FAIL hold_const: addr=%h aluop=%h required=80000010/a3",
                             mem_mem_addr, mem_aluop);
                end
            end
        end
    end

    initial begin
        in_t v;
        step("reset0", 1, 0, 6'd0, rnd_in());
        step("reset1", 1, 0, 6'd0, rnd_in());

        v = '0; v.wd = 5'd3; v.wreg = 1'b1; v.wdata = 32'hDEADBEEF;
        step("load_first", 0, 0, 6'd0, v);
        if (model.d.wdata !== 32'hDEADBEEF || model.valid !== 1'b1) begin
            n_mis++;
            $display("FAIL model_first: got=%h required=deadbeef", model.d.wdata);
        end

        for (int i = 1; i <= 4; i++) begin
            v = '0; v.wdata = i;
            step("b2b", 0, 0, 6'd0, v);
        end

        v = '0; v.whilo = 1'b1; v.hi = 32'h12345678;
        step("load_hilo", 0, 0, 6'd0, v);
        step("bubble", 0, 0, 6'b001111, rnd_in());

        v = rnd_in(); v.mem_addr = 32'h80000010; v.aluop = 8'hA3;
        step("load_addr", 0, 0, 6'd0, v);
        for (int i = 0; i < 3; i++)
            step("hold_addr", 0, 0, 6'b011111, rnd_in());

        v = rnd_in(); v.exc = 32'h00000100; v.pc = 32'hBFC00040;
        step("load_exc", 0, 0, 6'd0, v);
        step("hold_exc", 0, 0, 6'b011111, rnd_in());
        step("hold_exc2", 0, 0, 6'b011111, rnd_in());
        step("flush_hold", 0, 1, 6'b011111, rnd_in());

        step("load_r", 0, 0, 6'd0, rnd_in());
        step("hold_r", 0, 0, 6'b011111, rnd_in());
        step("rst_mid", 1, 0, 6'b011111, rnd_in());
        v = '0; v.cp0_we = 1'b1; v.cp0_addr = 5'd12; v.cp0_data = 32'h0000FF01;
        step("load_cp0", 0, 0, 6'd0, v);

        step("odd_stall", 0, 0, 6'b010000, rnd_in());
        step("flush_run", 0, 1, 6'd0, rnd_in());
        step("rst_flush", 1, 1, 6'b001111, rnd_in());
        v = '1;
        step("load_ones", 0, 0, 6'b000111, v);
        step("hold_ones", 0, 0, 6'b111111, rnd_in());

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d left required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: run did not end required=end");
        $fatal(1, "timeout");
    end

endmodule
